// File: rtl/pipe_ctrl_n_if.sv
// Bus between the pipeline controller and the pipeline registers / CP0.
// The master drives stall requests, exception code and EPC; the slave returns stop/flush/redirect and watchdog status.
interface pipe_ctrl_n_if #(
   parameter int STAGES = 6,
   parameter int WDOG_W = 8
);
   logic [STAGES-1:0] stall_req;
   logic [31:0]       exc_i;
   logic [31:0]       cp0_epc_i;
   logic [STAGES-1:0] stop;
   logic              flush;
   logic [31:0]       new_pc;
   logic [WDOG_W-1:0] stall_cnt;
   logic              wdog_timeout;

   modport master (
      output stall_req, exc_i, cp0_epc_i,
      input  stop, flush, new_pc, stall_cnt, wdog_timeout
   );

   modport slave (
      input  stall_req, exc_i, cp0_epc_i,
      output stop, flush, new_pc, stall_cnt, wdog_timeout
   );
endinterface

// File: rtl/pipe_ctrl_n.sv
// Pipeline stall/flush controller: stall masks, exception redirect with a
// multi-cycle flush, and a sticky stall watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal issue; stalls honoured, exceptions start a flush
// S_FLUSH | trailing flush cycles; inputs ignored, registered target out
module pipe_ctrl_n #(
   parameter int          STAGES       = 6,
   parameter logic [31:0] VEC_BASE     = 32'h0000_0000,
   parameter logic [31:0] INT_OFF      = 32'h0000_0020,
   parameter logic [31:0] EXC_OFF      = 32'h0000_0040,
   parameter int          FLUSH_CYCLES = 1,
   parameter int          WDOG_W       = 8
) (
   input logic          clk,
   input logic          rst,
   pipe_ctrl_n_if.slave bus
);
   localparam logic [0:0] S_RUN   = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   logic [0:0]        r_state;
   logic [3:0]        r_flush_cnt;
   logic [31:0]       r_target;
   logic [WDOG_W-1:0] r_stall_cnt;
   logic              r_wdog;

   logic              w_exc;
   logic [31:0]       w_vec;
   logic [STAGES-1:0] w_stop;

   assign w_exc = (r_state == S_RUN) && (bus.exc_i != 32'd0);

   always_comb begin
      case (bus.exc_i)
         32'h0000_0001: w_vec = VEC_BASE + INT_OFF;
         32'h0000_000e: w_vec = bus.cp0_epc_i;
         default:       w_vec = VEC_BASE + EXC_OFF;
      endcase
   end

   // stop[i] is set when any stage at or above i requests a stall
   always_comb begin
      w_stop = '0;
      if (rst && (r_state == S_RUN) && !w_exc) begin
         for (int i = 0; i < STAGES; i++) begin
            w_stop[i] = |(bus.stall_req >> i);
         end
      end
   end

   // Outputs are gated by reset so they drop at once when reset is asserted
   assign bus.stop         = w_stop;
   assign bus.flush        = rst & (w_exc | (r_state == S_FLUSH));
   assign bus.new_pc       = !rst ? 32'd0 :
                             w_exc ? w_vec :
                             (r_state == S_FLUSH) ? r_target : 32'd0;
   assign bus.stall_cnt    = r_stall_cnt;
   assign bus.wdog_timeout = r_wdog;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_RUN;
         r_flush_cnt <= 4'd0;
         r_target    <= 32'd0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_exc) begin
                  r_target <= w_vec;
                  if (FLUSH_CYCLES > 1) begin
                     r_state     <= S_FLUSH;
                     r_flush_cnt <= 4'(FLUSH_CYCLES - 1);
                  end
               end
            end
            S_FLUSH: begin
               r_flush_cnt <= r_flush_cnt - 4'd1;
               if (r_flush_cnt == 4'd1) r_state <= S_RUN;
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_wdog      <= 1'b0;
      end else begin
         if (|w_stop) begin
            r_stall_cnt <= (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + WDOG_W'(1);
         end else begin
            r_stall_cnt <= '0;
         end
         if (w_exc) r_wdog <= 1'b0;
         else if (&r_stall_cnt) r_wdog <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Scoreboard bench: two controller instances (single- and three-cycle flush)
// share stimulus; a reference model queues expected outputs, a monitor compares.
module tb_pipe_ctrl_n;
   typedef struct packed {
      logic [5:0]  stop;
      logic        flush;
      logic [31:0] pc;
      logic [7:0]  cnt;
      logic        to;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   exp_t q0[$];
   exp_t q1[$];

   int          m_fl  [2];
   logic [31:0] m_tg  [2];
   int          m_cnt [2];
   bit          m_to  [2];
   int          p_fc  [2] = '{1, 3};
   logic [31:0] p_base[2] = '{32'h0000_0000, 32'hBFC0_0000};
   int          p_max [2] = '{15, 255};

   pipe_ctrl_n_if #(.STAGES(6), .WDOG_W(4)) if_a ();
   pipe_ctrl_n_if #(.STAGES(6), .WDOG_W(8)) if_b ();

   pipe_ctrl_n #(.STAGES(6), .FLUSH_CYCLES(1), .WDOG_W(4)) u_dut_a (
      .clk(clk), .rst(rst), .bus(if_a.slave)
   );
   pipe_ctrl_n #(.STAGES(6), .VEC_BASE(32'hBFC0_0000), .FLUSH_CYCLES(3), .WDOG_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .bus(if_b.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] mask_of(input logic [5:0] s);
      int k = -1;
      for (int i = 0; i < 6; i++) if (s[i]) k = i;
      if (k < 0) return 6'd0;
      return 6'((1 << (k + 1)) - 1);
   endfunction

   function automatic logic [31:0] vec_of(input int d, input logic [31:0] code, input logic [31:0] epc);
      if (code == 32'h1) return p_base[d] + 32'h20;
      if (code == 32'he) return epc;
      return p_base[d] + 32'h40;
   endfunction

   task automatic step(input bit r, input logic [5:0] s, input logic [31:0] e, input logic [31:0] p);
      rst = r;
      if_a.stall_req = s; if_a.exc_i = e; if_a.cp0_epc_i = p;
      if_b.stall_req = s; if_b.exc_i = e; if_b.cp0_epc_i = p;
      for (int d = 0; d < 2; d++) begin
         exp_t x;
         x = '0;
         if (!r) begin
            m_fl[d] = 0; m_tg[d] = 32'd0; m_cnt[d] = 0; m_to[d] = 1'b0;
         end else if (m_fl[d] > 0) begin
            x.flush = 1'b1; x.pc = m_tg[d]; x.cnt = 8'(m_cnt[d]); x.to = m_to[d];
            m_fl[d]--;
            m_cnt[d] = 0;
         end else if (e != 32'd0) begin
            x.flush = 1'b1; x.pc = vec_of(d, e, p); x.cnt = 8'(m_cnt[d]); x.to = m_to[d];
            m_fl[d] = p_fc[d] - 1; m_tg[d] = x.pc; m_cnt[d] = 0; m_to[d] = 1'b0;
         end else begin
            x.stop = mask_of(s); x.cnt = 8'(m_cnt[d]); x.to = m_to[d];
            if (m_cnt[d] == p_max[d]) m_to[d] = 1'b1;
            if (x.stop == 6'd0) m_cnt[d] = 0;
            else if (m_cnt[d] < p_max[d]) m_cnt[d]++;
         end
         if (d == 0) q0.push_back(x);
         else q1.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input int d, input exp_t a, input exp_t x);
      checks += 5;
      if (a.stop !== x.stop) begin
         errors++; $display("FAIL dut%0d stop got %b exp %b t=%0t", d, a.stop, x.stop, $time);
      end
      if (a.flush !== x.flush) begin
         errors++; $display("FAIL dut%0d flush got %b exp %b t=%0t", d, a.flush, x.flush, $time);
      end
      if (a.pc !== x.pc) begin
         errors++; $display("FAIL dut%0d new_pc got %h exp %h t=%0t", d, a.pc, x.pc, $time);
      end
      if (a.cnt !== x.cnt) begin
         errors++; $display("FAIL dut%0d stall_cnt got %0d exp %0d t=%0t", d, a.cnt, x.cnt, $time);
      end
      if (a.to !== x.to) begin
         errors++; $display("FAIL dut%0d wdog_timeout got %b exp %b t=%0t", d, a.to, x.to, $time);
      end
   endtask

   initial begin
      exp_t a;
      exp_t x;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            x = q0.pop_front();
            a = '0;
            a.stop = if_a.stop; a.flush = if_a.flush; a.pc = if_a.new_pc;
            a.cnt = 8'(if_a.stall_cnt); a.to = if_a.wdog_timeout;
            cmp(0, a, x);
         end
         if (q1.size() > 0) begin
            x = q1.pop_front();
            a = '0;
            a.stop = if_b.stop; a.flush = if_b.flush; a.pc = if_b.new_pc;
            a.cnt = if_b.stall_cnt; a.to = if_b.wdog_timeout;
            cmp(1, a, x);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL sim_timeout no summary reached t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] codes[6];
      logic [31:0] e;
      logic [5:0]  s;
      for (int d = 0; d < 2; d++) begin
         m_fl[d] = 0; m_tg[d] = 32'd0; m_cnt[d] = 0; m_to[d] = 1'b0;
      end
      if_a.stall_req = '0; if_a.exc_i = '0; if_a.cp0_epc_i = '0;
      if_b.stall_req = '0; if_b.exc_i = '0; if_b.cp0_epc_i = '0;
      @(posedge clk);
      #1;
      step(0, 6'b000100, 32'h8, 32'h0);
      step(0, 6'b000000, 32'h0, 32'h0);
      // stall masks
      step(1, 6'b000100, 32'h0, 32'h0);
      step(1, 6'b010101, 32'h0, 32'h0);
      step(1, 6'b000000, 32'h0, 32'h0);
      // syscall with a concurrent stall
      step(1, 6'b001000, 32'h8, 32'h0);
      repeat (3) step(1, 6'b000000, 32'h0, 32'h0);
      // interrupt, then a syscall that dut1 must drop
      step(1, 6'b000000, 32'h1, 32'h0);
      step(1, 6'b000000, 32'h8, 32'h0);
      repeat (2) step(1, 6'b000000, 32'h0, 32'h0);
      // eret and an unknown code
      step(1, 6'b000000, 32'he, 32'h0000_1234);
      repeat (3) step(1, 6'b000000, 32'h0, 32'h0);
      step(1, 6'b000000, 32'h5, 32'h0000_1234);
      repeat (3) step(1, 6'b000000, 32'h0, 32'h0);
      // watchdog saturation then cleared by an exception
      repeat (20) step(1, 6'b000001, 32'h0, 32'h0);
      step(1, 6'b000001, 32'h8, 32'h0);
      repeat (3) step(1, 6'b000000, 32'h0, 32'h0);
      // reset asserted mid-flush, between edges
      step(1, 6'b000000, 32'h1, 32'h0);
      step(1, 6'b000010, 32'h0, 32'h0);
      step(0, 6'b000010, 32'h0, 32'h0);
      step(0, 6'b000010, 32'h0, 32'h0);
      step(1, 6'b000010, 32'h0, 32'h0);
      step(1, 6'b000000, 32'h0, 32'h0);
      // long stall for the 8-bit watchdog
      repeat (270) step(1, 6'($urandom_range(1, 63)), 32'h0, 32'h0);
      step(1, 6'b000000, 32'ha, 32'h0);
      repeat (3) step(1, 6'b000000, 32'h0, 32'h0);
      // random traffic
      codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'he;
      codes[3] = 32'ha; codes[4] = 32'h5; codes[5] = 32'h0;
      for (int n = 0; n < 400; n++) begin
         s = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
         e = 32'h0;
         if ($urandom_range(0, 7) == 0) begin
            e = codes[$urandom_range(0, 5)];
            if (e == 32'h0) e = $urandom | 32'h1;
         end
         step(($urandom_range(0, 99) != 0), s, e, $urandom);
      end
      step(1, 6'b000000, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      checks++;
      if (q0.size() + q1.size() != 0) begin
         errors++;
         $display("FAIL drain left %0d expected entries, exp 0", q0.size() + q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
